// File: rtl/mac_pkg.sv
// Shared mode constants and accumulator range helper for the mac_pipe arithmetic core.
package mac_pkg;

  localparam int MODE_SIGNED = 1;
  localparam int MODE_SAT    = 1;
  localparam int LIM_W       = 65;

  // Upper or lower accumulator limit for an acc_w-bit register, as an LIM_W-bit pattern.
  function automatic logic [LIM_W-1:0] acc_limit(input int acc_w, input logic sgn,
                                                 input logic upper);
    logic [LIM_W-1:0] one;
    one = {{(LIM_W-1){1'b0}}, 1'b1};
    if (sgn) begin
      return upper ? (one << (acc_w - 1)) - one : ~(one << (acc_w - 1)) + one;
    end
    return upper ? (one << acc_w) - one : '0;
  endfunction

endpackage

// File: rtl/mac_mul_pipe.sv
// Multiplier followed by a STAGES-deep register chain carrying product, valid and clear.
module mac_mul_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SIGNED = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  input  logic               clear,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               clr
);

  localparam logic IS_SIGNED = (SIGNED == MODE_SIGNED);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod_now;
  logic [2*WIDTH-1:0] prod_q  [STAGES];
  logic               valid_q [STAGES];
  logic               clr_q   [STAGES];

  // Extending both operands to 2*WIDTH makes the truncated product exact in either mode.
  always_comb begin
    a_ext    = {{WIDTH{IS_SIGNED & ina[WIDTH-1]}}, ina};
    b_ext    = {{WIDTH{IS_SIGNED & inb[WIDTH-1]}}, inb};
    prod_now = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        prod_q[i]  <= '0;
        valid_q[i] <= 1'b0;
        clr_q[i]   <= 1'b0;
      end
    end else if (enable) begin
      prod_q[0]  <= prod_now;
      valid_q[0] <= in_valid;
      clr_q[0]   <= clear;
      for (int i = 1; i < STAGES; i++) begin
        prod_q[i]  <= prod_q[i-1];
        valid_q[i] <= valid_q[i-1];
        clr_q[i]   <= clr_q[i-1];
      end
    end
  end

  assign product = prod_q[STAGES-1];
  assign valid   = valid_q[STAGES-1];
  assign clr     = clr_q[STAGES-1];

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate: multiplier chain plus accumulate stage with
// saturating or wrapping overflow handling and a sticky overflow flag.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int STAGES    = 2,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     ina,
  input  logic [WIDTH-1:0]     inb,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam logic IS_SIGNED = (SIGNED == MODE_SIGNED);
  localparam logic IS_SAT    = (SATURATE == MODE_SAT);
  localparam logic [LIM_W-1:0] HI_FULL = acc_limit(ACC_WIDTH, IS_SIGNED, 1'b1);
  localparam logic [LIM_W-1:0] LO_FULL = acc_limit(ACC_WIDTH, IS_SIGNED, 1'b0);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = HI_FULL[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = LO_FULL[ACC_WIDTH-1:0];

  logic [2*WIDTH-1:0] prod;
  logic               prod_valid;
  logic               prod_clear;

  mac_mul_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES),
    .SIGNED(SIGNED)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .in_valid(in_valid),
    .clear   (clear),
    .ina     (ina),
    .inb     (inb),
    .product (prod),
    .valid   (prod_valid),
    .clr     (prod_clear)
  );

  logic [ACC_WIDTH:0] ext_prod;
  logic [ACC_WIDTH:0] acc_ext;
  logic [ACC_WIDTH:0] sum;
  logic               sum_ovf;
  logic               sum_low;

  // One guard bit suffices: signed overflow shows as disagreeing top bits, unsigned as a carry.
  always_comb begin
    ext_prod = {{(ACC_WIDTH + 1 - 2*WIDTH){IS_SIGNED & prod[2*WIDTH-1]}}, prod};
    acc_ext  = {IS_SIGNED & out[ACC_WIDTH-1], out};
    sum      = acc_ext + ext_prod;
    sum_ovf  = IS_SIGNED ? (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
    sum_low  = IS_SIGNED & sum[ACC_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (enable) begin
      out_valid <= prod_valid;
      if (prod_valid && prod_clear) begin
        out      <= ext_prod[ACC_WIDTH-1:0];
        overflow <= 1'b0;
      end else if (prod_valid) begin
        if (sum_ovf) begin
          overflow <= 1'b1;
          if (IS_SAT) out <= sum_low ? ACC_MIN : ACC_MAX;
          else        out <= sum[ACC_WIDTH-1:0];
        end else begin
          out <= sum[ACC_WIDTH-1:0];
        end
      end else if (prod_clear) begin
        out      <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench: four mac_pipe configurations share one stimulus stream and are
// checked against an integer reference model of the accumulate rules.
module tb_mac_pipe;

  logic       clk = 1'b0;
  logic       reset, enable, in_valid, clear;
  logic [7:0] ina, inb;

  logic [19:0] out0, out2, out3;
  logic [15:0] out1;
  logic        ov0, ov1, ov2, ov3;
  logic        of0, of1, of2, of3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_pipe #(.WIDTH(8), .ACC_WIDTH(20), .STAGES(2), .SIGNED(1), .SATURATE(1)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .clear(clear),
    .ina(ina), .inb(inb), .out(out0), .out_valid(ov0), .overflow(of0));
  mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .STAGES(2), .SIGNED(0), .SATURATE(0)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .clear(clear),
    .ina(ina), .inb(inb), .out(out1), .out_valid(ov1), .overflow(of1));
  mac_pipe #(.WIDTH(8), .ACC_WIDTH(20), .STAGES(1), .SIGNED(1), .SATURATE(1)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .clear(clear),
    .ina(ina), .inb(inb), .out(out2), .out_valid(ov2), .overflow(of2));
  mac_pipe #(.WIDTH(8), .ACC_WIDTH(20), .STAGES(4), .SIGNED(1), .SATURATE(1)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .clear(clear),
    .ina(ina), .inb(inb), .out(out3), .out_valid(ov3), .overflow(of3));

  function automatic int cfg_aw(int i);  return (i == 1) ? 16 : 20; endfunction
  function automatic bit cfg_sgn(int i); return i != 1; endfunction
  function automatic bit cfg_sat(int i); return i != 1; endfunction
  function automatic int cfg_lat(int i);
    case (i)
      2:       return 2;
      3:       return 5;
      default: return 3;
    endcase
  endfunction

  typedef struct packed {
    logic        v;
    logic [63:0] acc;
    logic        ovf;
  } exp_t;

  exp_t   q0[$], q1[$], q2[$], q3[$];
  exp_t   hold [4];
  longint acc_m [4];
  logic   ovf_m [4];
  bit     started  = 0;
  bit     last_en  = 0;
  bit     last_rst = 0;

  function automatic void q_push(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic bit q_pop(int i, output exp_t e);
    e = '0;
    case (i)
      0: begin if (q0.size() == 0) return 0; e = q0.pop_front(); end
      1: begin if (q1.size() == 0) return 0; e = q1.pop_front(); end
      2: begin if (q2.size() == 0) return 0; e = q2.pop_front(); end
      default: begin if (q3.size() == 0) return 0; e = q3.pop_front(); end
    endcase
    return 1;
  endfunction

  function automatic void check(string name, int d, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d required=%0d", name, d, act, req);
    end
  endfunction

  // Reference: mathematical accumulator value per configuration, clamped or wrapped on overflow.
  function automatic exp_t step(int i, logic v, logic c, logic [7:0] a, logic [7:0] b);
    exp_t   e;
    longint p, m, mx, mn, s, r;
    bit     sg;
    sg = cfg_sgn(i);
    m  = longint'(1) << cfg_aw(i);
    mx = sg ? (m / 2 - 1) : (m - 1);
    mn = sg ? -(m / 2) : 0;
    p  = sg ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    if (v && c) begin
      acc_m[i] = p;
      ovf_m[i] = 1'b0;
    end else if (v) begin
      s = acc_m[i] + p;
      if (s > mx || s < mn) begin
        ovf_m[i] = 1'b1;
        if (cfg_sat(i)) begin
          acc_m[i] = (s > mx) ? mx : mn;
        end else begin
          r = (s - mn) % m;
          if (r < 0) r = r + m;
          acc_m[i] = r + mn;
        end
      end else begin
        acc_m[i] = s;
      end
    end else if (c) begin
      acc_m[i] = 0;
      ovf_m[i] = 1'b0;
    end
    e.v   = v;
    e.acc = 64'(acc_m[i] & (m - 1));
    e.ovf = ovf_m[i];
    return e;
  endfunction

  // Every enabled cycle pushes the output expected STAGES+1 enabled cycles later.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        for (int i = 0; i < 4; i++) begin
          acc_m[i] = 0;
          ovf_m[i] = 1'b0;
          for (int k = 0; k < cfg_lat(i) - 1; k++) q_push(i, '0);
        end
        started  = 1;
        last_rst = 1;
        last_en  = 0;
      end else begin
        last_rst = 0;
        last_en  = enable;
        if (enable && started)
          for (int i = 0; i < 4; i++) q_push(i, step(i, in_valid, clear, ina, inb));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 4; i++) begin
          exp_t        e;
          logic [63:0] o;
          logic        v, f;
          case (i)
            0: begin o = 64'(out0); v = ov0; f = of0; end
            1: begin o = 64'(out1); v = ov1; f = of1; end
            2: begin o = 64'(out2); v = ov2; f = of2; end
            default: begin o = 64'(out3); v = ov3; f = of3; end
          endcase
          if (last_rst) begin
            e = '0;
          end else if (last_en) begin
            if (!q_pop(i, e)) begin
              checks++;
              errors++;
              $display("FAIL queue dut%0d actual=empty required=entry", i);
              e = hold[i];
            end
          end else begin
            e = hold[i];
          end
          hold[i] = e;
          check("out", i, o, e.acc);
          check("out_valid", i, 64'(v), 64'(e.v));
          check("overflow", i, 64'(f), 64'(e.ovf));
        end
      end
    end
  end

  task automatic cyc(input logic en, input logic v, input logic c,
                     input logic [7:0] a, input logic [7:0] b);
    reset    = 1'b0;
    enable   = en;
    in_valid = v;
    clear    = c;
    ina      = a;
    inb      = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  // Reset arrives with a valid sample and enable low: reset must still win.
  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b1;
    clear    = 1'b1;
    ina      = 8'd9;
    inb      = 8'd9;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; clear = 1'b0; ina = '0; inb = '0;
    @(negedge clk);
    do_reset();

    cyc(1, 1, 1, 8'd3, 8'd4);
    cyc(1, 1, 0, 8'd5, 8'd6);
    cyc(1, 1, 0, 8'hFE, 8'd7);
    idle(6);
    check("basic_out", 0, 64'(out0), 64'd28);
    check("basic_ovf", 0, 64'(of0), 64'd0);

    do_reset();
    cyc(1, 1, 1, 8'd2, 8'd3);
    idle(6);
    check("lat_out", 2, 64'(out2), 64'd6);
    check("lat_out", 3, 64'(out3), 64'd6);

    cyc(1, 1, 1, 8'h80, 8'h80);
    repeat (31) cyc(1, 1, 0, 8'h80, 8'h80);
    idle(6);
    check("sat_out", 0, 64'(out0), 64'd524287);
    check("sat_ovf", 0, 64'(of0), 64'd1);
    cyc(1, 1, 0, 8'h80, 8'h80);
    cyc(1, 1, 0, 8'hFF, 8'd1);
    idle(5);
    check("sat_off", 0, 64'(out0), 64'd524286);
    cyc(1, 1, 1, 8'd1, 8'd1);
    idle(6);
    check("sat_clr_out", 0, 64'(out0), 64'd1);
    check("sat_clr_ovf", 0, 64'(of0), 64'd0);

    cyc(1, 1, 1, 8'hFF, 8'hFF);
    cyc(1, 1, 0, 8'hFF, 8'hFF);
    idle(6);
    check("wrap_out", 1, 64'(out1), 64'd64514);
    check("wrap_ovf", 1, 64'(of1), 64'd1);

    cyc(1, 1, 1, 8'd7, 8'd9);
    cyc(1, 1, 0, 8'd3, 8'd5);
    repeat (3) cyc(0, 1, 0, 8'd100, 8'd100);
    cyc(1, 1, 0, 8'd2, 8'd2);
    idle(8);
    check("stall_out", 0, 64'(out0), 64'd82);

    cyc(1, 1, 1, 8'd10, 8'd10);
    cyc(1, 0, 1, 8'd0, 8'd0);
    idle(6);
    check("bubble_out", 0, 64'(out0), 64'd0);
    check("bubble_valid", 0, 64'(ov0), 64'd0);

    cyc(1, 1, 1, 8'd5, 8'd5);
    cyc(1, 1, 0, 8'd6, 8'd6);
    do_reset();
    check("rst_out", 0, 64'(out0), 64'd0);
    check("rst_valid", 0, 64'(ov0), 64'd0);
    idle(8);

    repeat (400) begin
      if ($urandom_range(99) == 0) do_reset();
      else cyc($urandom_range(9) != 0, $urandom_range(9) < 7, $urandom_range(9) == 0,
               8'($urandom), 8'($urandom));
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
